handle_table: RTL and testbench

Parametrised handle translation unit with a valid/ready pipeline. It sits between the core and memory. Handle-command accesses allocate, program, read back and free handle entries. Every other access is translated from handle-relative form to a physical address, with per-handle bounds and overflow checking. It has one registered output stage, a free-handle allocator and a free counter.

---
 rtl/handle_table_pkg.sv | 27 ++
 rtl/handle_table_entry.sv | 55 +++++
 rtl/handle_table.sv | 208 ++++++++++++++++++++
 tb/tb_handle_table.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handle_table_pkg.sv
// Shared encodings for the handle translation unit: request ops, entry states
// and the handle-command field constants.
package handle_table_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2
    } op_e;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_RESERVED = 2'd1,
        ST_MAPPED   = 2'd2
    } state_e;

    // The all-ones id on a READ command requests allocation.
    function automatic int alloc_id(input int hndl_width);
        return (1 << hndl_width) - 1;
    endfunction

    // Address bit just above the id selects base (0) or limit (1).
    function automatic int field_sel_bit(input int hndl_width);
        return hndl_width;
    endfunction

endpackage

// File: rtl/handle_table_entry.sv
// One handle entry: lifecycle state, physical base and inclusive offset limit,
// with its reserve / program / invalidate update rules.
module handle_entry
    import handle_table_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int OFS_WIDTH  = 27
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_reserve,
    input  logic                  i_wr_base,
    input  logic                  i_wr_limit,
    input  logic [ADDR_WIDTH-1:0] i_data,
    output logic [1:0]            o_state,
    output logic [ADDR_WIDTH-1:0] o_base,
    output logic [OFS_WIDTH-1:0]  o_limit
);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [OFS_WIDTH-1:0]  r_limit;

    logic w_invalidate;
    logic w_live;

    assign w_invalidate = i_wr_base & (i_data == '0);
    assign w_live       = (r_state != ST_FREE);

    // NOTE: the entry fields are reset, not just the state, because a FREE
    // entry must read back base 0 and limit all ones.
    always_ff @(posedge i_clock) begin
        if (i_reset || w_invalidate) begin
            r_state <= ST_FREE;
            r_base  <= '0;
            r_limit <= '1;
        end else begin
            if (i_reserve) begin
                r_state <= ST_RESERVED;
            end
            if (i_wr_base && w_live) begin
                r_base  <= i_data;
                r_state <= ST_MAPPED;
            end
            if (i_wr_limit && w_live) begin
                r_limit <= i_data[OFS_WIDTH-1:0];
            end
        end
    end

    assign o_state = r_state;
    assign o_base  = r_base;
    assign o_limit = r_limit;

endmodule

// File: rtl/handle_table.sv
// Handle translation unit: decodes handle commands, translates handle-relative
// accesses with bounds/overflow faults, and registers one response stage.
module handle_table
    import handle_table_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int HNDL_WIDTH = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [ADDR_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2:0]            o_op,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [ADDR_WIDTH-1:0] o_data,
    output logic                  o_fault,
    output logic [HNDL_WIDTH-1:0] o_free_count
);

    localparam int OFS_WIDTH   = ADDR_WIDTH - HNDL_WIDTH - 1;
    localparam int NUM_ENTRIES = (1 << HNDL_WIDTH) - 1;
    localparam int FIELD_BIT   = field_sel_bit(HNDL_WIDTH);
    localparam logic [HNDL_WIDTH-1:0] ALLOC_ID = HNDL_WIDTH'(alloc_id(HNDL_WIDTH));

    logic                  r_valid;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [ADDR_WIDTH-1:0] r_data;
    logic                  r_fault;
    logic [HNDL_WIDTH-1:0] r_free_count;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_is_cmd;
    logic                  w_is_read;
    logic                  w_is_write;
    logic                  w_field_limit;
    logic                  w_do_alloc;
    logic [HNDL_WIDTH-1:0] w_cmd_id;
    logic [HNDL_WIDTH-1:0] w_xl_hndl;
    logic [OFS_WIDTH-1:0]  w_offset;

    logic [1:0]            w_state [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] w_base  [NUM_ENTRIES];
    logic [OFS_WIDTH-1:0]  w_limit [NUM_ENTRIES];

    logic                  w_alloc_found;
    logic [HNDL_WIDTH-1:0] w_alloc_id;
    logic [HNDL_WIDTH-1:0] w_free_pop;

    logic [ADDR_WIDTH-1:0] w_cmd_base;
    logic [OFS_WIDTH-1:0]  w_cmd_limit;
    logic [1:0]            w_xl_state;
    logic [ADDR_WIDTH-1:0] w_xl_base;
    logic [OFS_WIDTH-1:0]  w_xl_limit;
    logic [ADDR_WIDTH:0]   w_sum;
    logic                  w_xl_fault;

    logic [2:0]            w_nxt_op;
    logic [ADDR_WIDTH-1:0] w_nxt_address;
    logic [ADDR_WIDTH-1:0] w_nxt_data;
    logic                  w_nxt_fault;

    assign w_ready  = !r_valid | i_ready;
    assign w_accept = i_valid & w_ready;

    assign w_is_cmd      = &i_address[ADDR_WIDTH-1:OFS_WIDTH];
    assign w_is_read     = (i_op == OP_READ);
    assign w_is_write    = (i_op == OP_WRITE);
    assign w_cmd_id      = i_address[HNDL_WIDTH-1:0];
    assign w_field_limit = i_address[FIELD_BIT];
    assign w_xl_hndl     = i_address[ADDR_WIDTH-2:OFS_WIDTH];
    assign w_offset      = i_address[OFS_WIDTH-1:0];
    assign w_do_alloc    = w_is_cmd & w_is_read & (w_cmd_id == ALLOC_ID) & w_alloc_found;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        logic w_hit;
        assign w_hit = w_accept & w_is_cmd & w_is_write & (w_cmd_id == HNDL_WIDTH'(g));

        handle_entry #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .OFS_WIDTH  (OFS_WIDTH)
        ) u_entry (
            .i_clock    (i_clock),
            .i_reset    (i_reset),
            .i_reserve  (w_accept & w_do_alloc & (w_alloc_id == HNDL_WIDTH'(g))),
            .i_wr_base  (w_hit & !w_field_limit),
            .i_wr_limit (w_hit & w_field_limit),
            .i_data     (i_data),
            .o_state    (w_state[g]),
            .o_base     (w_base[g]),
            .o_limit    (w_limit[g])
        );
    end

    // Scan downward so the lowest-numbered FREE entry is the last one kept.
    always_comb begin
        w_alloc_found = 1'b0;
        w_alloc_id    = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_state[i] == ST_FREE) begin
                w_alloc_found = 1'b1;
                w_alloc_id    = HNDL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_free_pop = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_state[i] == ST_FREE) begin
                w_free_pop = w_free_pop + HNDL_WIDTH'(1);
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_cmd_base  = '0;
        w_cmd_limit = '0;
        w_xl_state  = ST_FREE;
        w_xl_base   = '0;
        w_xl_limit  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_cmd_id == HNDL_WIDTH'(i)) begin
                w_cmd_base  = w_base[i];
                w_cmd_limit = w_limit[i];
            end
            if (w_xl_hndl == HNDL_WIDTH'(i)) begin
                w_xl_state = w_state[i];
                w_xl_base  = w_base[i];
                w_xl_limit = w_limit[i];
            end
        end
    end

    // The extra top bit of the sum is the carry out of the physical address.
    assign w_sum      = {1'b0, w_xl_base} + {{(HNDL_WIDTH + 2){1'b0}}, w_offset};
    assign w_xl_fault = (w_xl_state != ST_MAPPED) | (w_offset > w_xl_limit) | w_sum[ADDR_WIDTH];

    always_comb begin
        w_nxt_op      = OP_NOP;
        w_nxt_address = '0;
        w_nxt_data    = '0;
        w_nxt_fault   = 1'b0;
        if (i_op != OP_NOP) begin
            if (w_is_cmd) begin
                if (w_is_read) begin
                    if (w_cmd_id == ALLOC_ID) begin
                        w_nxt_data = w_alloc_found ? ADDR_WIDTH'(w_alloc_id) : '1;
                    end else if (w_field_limit) begin
                        w_nxt_data = ADDR_WIDTH'(w_cmd_limit);
                    end else begin
                        w_nxt_data = w_cmd_base;
                    end
                end
            end else if (w_xl_fault) begin
                w_nxt_fault = 1'b1;
            end else begin
                w_nxt_op      = i_op;
                w_nxt_address = w_sum[ADDR_WIDTH-1:0];
                w_nxt_data    = i_data;
            end
        end
    end

    // A stalled response holds; a drained slot reloads on the same edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_op      <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_fault   <= 1'b0;
        end else if (w_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_op      <= w_nxt_op;
                r_address <= w_nxt_address;
                r_data    <= w_nxt_data;
                r_fault   <= w_nxt_fault;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_free_count <= HNDL_WIDTH'(NUM_ENTRIES);
        end else begin
            r_free_count <= w_free_pop;
        end
    end

    assign o_ready      = w_ready;
    assign o_valid      = r_valid;
    assign o_op         = r_op;
    assign o_address    = r_address;
    assign o_data       = r_data;
    assign o_fault      = r_fault;
    assign o_free_count = r_free_count;

endmodule

// File: tb/tb_handle_table.sv
// Bench for handle_table: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a transaction model.
module tb_handle_table;

    localparam int AW = 32;
    localparam int HW = 4;
    localparam int NE = 15;
    localparam int S_FREE = 0;
    localparam int S_RES  = 1;
    localparam int S_MAP  = 2;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_valid;
    logic          o_ready;
    logic [2:0]    i_op;
    logic [AW-1:0] i_address;
    logic [AW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [2:0]    o_op;
    logic [AW-1:0] o_address;
    logic [AW-1:0] o_data;
    logic          o_fault;
    logic [HW-1:0] o_free_count;

    always #5 clk = ~clk;

    handle_table #(
        .ADDR_WIDTH (AW),
        .HNDL_WIDTH (HW)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_op         (i_op),
        .i_address    (i_address),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_op         (o_op),
        .o_address    (o_address),
        .o_data       (o_data),
        .o_fault      (o_fault),
        .o_free_count (o_free_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: table contents and the expected response register.
    int          m_state [NE];
    logic [31:0] m_base  [NE];
    logic [26:0] m_limit [NE];
    logic        e_valid;
    logic [2:0]  e_op;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_fault;
    int          e_free;
    bit          checks_on = 1'b0;

    function automatic int free_cnt();
        int n = 0;
        for (int k = 0; k < NE; k++) begin
            if (m_state[k] == S_FREE) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NE; k++) begin
            m_state[k] = S_FREE;
            m_base[k]  = '0;
            m_limit[k] = '1;
        end
        e_valid = 1'b0;
        e_op    = '0;
        e_addr  = '0;
        e_data  = '0;
        e_fault = 1'b0;
        e_free  = NE;
    endtask

    task automatic model_request(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int          id;
        int          h;
        logic [26:0] off;
        logic [63:0] sum;
        e_op    = '0;
        e_addr  = '0;
        e_data  = '0;
        e_fault = 1'b0;
        if (op == 3'd0) return;
        if (a[31:27] == 5'h1F) begin
            id = int'(a[3:0]);
            if (op == 3'd1) begin
                if (id == 15) begin
                    e_data = '1;
                    for (int k = 0; k < NE; k++) begin
                        if (m_state[k] == S_FREE) begin
                            m_state[k] = S_RES;
                            e_data     = 32'(k);
                            break;
                        end
                    end
                end else begin
                    e_data = a[4] ? {5'd0, m_limit[id]} : m_base[id];
                end
            end else if (op == 3'd2 && id != 15) begin
                if (!a[4]) begin
                    if (d == 0) begin
                        m_state[id] = S_FREE;
                        m_base[id]  = '0;
                        m_limit[id] = '1;
                    end else if (m_state[id] != S_FREE) begin
                        m_base[id]  = d;
                        m_state[id] = S_MAP;
                    end
                end else if (m_state[id] != S_FREE) begin
                    m_limit[id] = d[26:0];
                end
            end
        end else begin
            h   = int'(a[30:27]);
            off = a[26:0];
            if (h == 15 || m_state[h] != S_MAP || off > m_limit[h]) begin
                e_fault = 1'b1;
            end else begin
                sum = 64'(m_base[h]) + 64'(off);
                if (sum > 64'h0000_0000_FFFF_FFFF) begin
                    e_fault = 1'b1;
                end else begin
                    e_op   = op;
                    e_addr = sum[31:0];
                    e_data = d;
                end
            end
        end
    endtask

    // Compare the DUT against the model, then advance the model over the next edge.
    initial begin : compare
        bit acc;
        int nf;
        forever begin
            @(negedge clk);
            if (checks_on) begin
                check("o_valid", 32'(o_valid), 32'(e_valid));
                check("o_ready", 32'(o_ready), 32'(!e_valid || i_ready));
                check("o_free_count", 32'(o_free_count), 32'(e_free));
                if (e_valid) begin
                    check("o_op", 32'(o_op), 32'(e_op));
                    check("o_address", o_address, e_addr);
                    check("o_data", o_data, e_data);
                    check("o_fault", 32'(o_fault), 32'(e_fault));
                end
            end
            if (i_reset) begin
                model_reset();
            end else begin
                acc = i_valid && (!e_valid || i_ready);
                nf  = free_cnt();
                if (acc) begin
                    model_request(i_op, i_address, i_data);
                    e_valid = 1'b1;
                end else if (!e_valid || i_ready) begin
                    e_valid = 1'b0;
                end
                e_free = nf;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        i_valid   = 1'b1;
        i_op      = op;
        i_address = a;
        i_data    = d;
        @(posedge clk);
        #2;
        i_valid   = 1'b0;
        i_op      = '0;
        i_address = '0;
        i_data    = '0;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        i_reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  r_id;
        logic [3:0]  r_h;
        logic [26:0] r_off;
        model_reset();
        i_reset   = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_op      = '0;
        i_address = '0;
        i_data    = '0;
        @(posedge clk);
        #2;
        checks_on = 1'b1;
        @(posedge clk);
        #2;
        i_reset = 1'b0;

        check("reset o_valid", 32'(o_valid), 32'd0);
        check("reset o_free_count", 32'(o_free_count), 32'd15);
        check("reset o_data", o_data, 32'd0);
        check("reset o_address", o_address, 32'd0);
        check("reset o_fault", 32'(o_fault), 32'd0);

        send(3'd1, 32'hF800000F, 32'd0);
        check("alloc first", o_data, 32'd0);
        send(3'd1, 32'hF800000F, 32'd0);
        check("alloc second", o_data, 32'd1);
        check("free after alloc", 32'(o_free_count), 32'd14);

        send(3'd2, 32'hF8000000, 32'h00010000);
        check("write base resp", o_data, 32'd0);
        send(3'd1, 32'h00000040, 32'h0);
        check("xl op", 32'(o_op), 32'd1);
        check("xl address", o_address, 32'h00010040);
        check("xl fault", 32'(o_fault), 32'd0);

        send(3'd2, 32'hF8000010, 32'h3F);
        send(3'd1, 32'h00000040, 32'h0);
        check("over limit fault", 32'(o_fault), 32'd1);
        check("over limit op", 32'(o_op), 32'd0);
        send(3'd1, 32'h0000003F, 32'h0);
        check("at limit fault", 32'(o_fault), 32'd0);
        check("at limit address", o_address, 32'h0001003F);
        send(3'd1, 32'hF8000010, 32'h0);
        check("read limit", o_data, 32'h3F);

        send(3'd1, 32'h08000004, 32'h0);
        check("unmapped fault", 32'(o_fault), 32'd1);
        send(3'd2, 32'hF8000010, 32'h07FFFFFF);
        send(3'd2, 32'hF8000000, 32'hFFFFFFF0);
        send(3'd1, 32'h00000020, 32'h0);
        check("carry fault", 32'(o_fault), 32'd1);
        check("carry address", o_address, 32'd0);
        send(3'd2, 32'h0000000F, 32'hA5A5A5A5);
        check("top address", o_address, 32'hFFFFFFFF);
        check("top data", o_data, 32'hA5A5A5A5);
        check("top op", 32'(o_op), 32'd2);

        do_reset();
        for (int k = 0; k < NE; k++) begin
            send(3'd1, 32'hF800000F, 32'd0);
            check("alloc seq", o_data, 32'(k));
        end
        send(3'd1, 32'hF800000F, 32'd0);
        check("alloc exhausted", o_data, 32'hFFFFFFFF);
        check("free exhausted", 32'(o_free_count), 32'd0);
        send(3'd2, 32'hF8000003, 32'd0);
        send(3'd1, 32'hF800000F, 32'd0);
        check("alloc after free", o_data, 32'd3);

        send(3'd2, 32'hF8000005, 32'd0);
        idle();
        i_ready   = 1'b0;
        i_valid   = 1'b1;
        i_op      = 3'd1;
        i_address = 32'hF800000F;
        @(posedge clk);
        #2;
        i_op      = 3'd2;
        i_address = 32'hF8000007;
        i_data    = 32'd0;
        for (int k = 0; k < 3; k++) begin
            check("stall o_ready", 32'(o_ready), 32'd0);
            check("stall o_valid", 32'(o_valid), 32'd1);
            check("stall o_data", o_data, 32'd5);
            @(posedge clk);
            #2;
        end
        check("stall table", 32'(o_free_count), 32'd0);
        i_reset = 1'b1;
        @(posedge clk);
        #2;
        check("reset in stall", 32'(o_valid), 32'd0);
        i_ready   = 1'b1;
        i_op      = 3'd1;
        i_address = 32'hF800000F;
        @(posedge clk);
        #2;
        check("reset beats accept", 32'(o_valid), 32'd0);
        i_reset = 1'b0;
        idle();
        check("free after reset", 32'(o_free_count), 32'd15);

        for (int c = 0; c < 3000; c++) begin
            i_reset = ($urandom_range(0, 299) == 0);
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 4) != 0);
            i_op    = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin
                r_id      = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                i_address = {5'h1F, 22'd0, 1'($urandom_range(0, 1)), r_id};
            end else begin
                r_h       = 4'($urandom_range(0, 15));
                r_off     = ($urandom_range(0, 1) == 0) ? 27'($urandom_range(0, 255)) : 27'($urandom);
                i_address = {1'($urandom_range(0, 1)), r_h, r_off};
            end
            case ($urandom_range(0, 7))
                0:       i_data = 32'd0;
                1:       i_data = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
                2, 3:    i_data = 32'($urandom_range(0, 255));
                default: i_data = $urandom;
            endcase
            @(posedge clk);
            #2;
        end

        i_reset = 1'b0;
        i_ready = 1'b1;
        repeat (3) idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
